prim_shadow_writer: RTL and testbench

//  Initiator that updates shadowed registers from hardware: clears the target's phase, issues the
//  two identical writes, reads back and checks the result. One update at a time on a simple
//  req/gnt register bus. Used by HW agents (keymgr/OTP loaders) that program shadowed CSRs.

---
 rtl/prim_shadow_writer_pkg.sv | 29 ++
 rtl/prim_shadow_writer_if.sv | 33 +++
 rtl/prim_shadow_wr_timer.sv | 27 ++
 rtl/prim_shadow_writer.sv | 133 +++++++++++++
 tb/tb_prim_shadow_writer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prim_shadow_writer_pkg.sv
// prim_shadow_writer_pkg: status codes and FSM state encoding shared by the shadow-register writer.
package prim_shadow_writer_pkg;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        UPD_ERR  = 2'd1,
        MISMATCH = 2'd2,
        TIMEOUT  = 2'd3
    } shadow_wr_status_e;

    // Sparse codes: a corrupted state word lands in the default branch and recovers to IDLE.
    typedef enum logic [5:0] {
        IDLE = 6'b001101,
        CLR  = 6'b010110,
        WR0  = 6'b100011,
        WR1  = 6'b111000,
        VFY  = 6'b011011,
        RESP = 6'b101110
    } shadow_wr_state_e;

    function automatic logic is_read_state(shadow_wr_state_e s);
        return (s == CLR) || (s == VFY);
    endfunction

    function automatic logic is_write_state(shadow_wr_state_e s);
        return (s == WR0) || (s == WR1);
    endfunction

endpackage

// File: rtl/prim_shadow_writer_if.sv
// prim_shadow_writer_if: update request/response and req/gnt register-bus signals of the shadow writer.
interface prim_shadow_writer_if import prim_shadow_writer_pkg::*; #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) ();
    logic              upd_valid_i;
    logic              upd_ready_o;
    logic [AW-1:0]     upd_addr_i;
    logic [DW-1:0]     upd_data_i;
    logic              done_o;
    shadow_wr_status_e status_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [AW-1:0]     bus_addr_o;
    logic [DW-1:0]     bus_wdata_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [DW-1:0]     bus_rdata_i;
    logic              err_update_i;
    logic              err_storage_i;

    modport master (
        input  upd_valid_i, upd_addr_i, upd_data_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
               err_update_i, err_storage_i,
        output upd_ready_o, done_o, status_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );

    modport slave (
        output upd_valid_i, upd_addr_i, upd_data_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
               err_update_i, err_storage_i,
        input  upd_ready_o, done_o, status_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );
endinterface

// File: rtl/prim_shadow_wr_timer.sv
// prim_shadow_wr_timer: per-access wait counter; expire_o fires on the TimeoutCycles-th waiting cycle.
module prim_shadow_wr_timer #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);
    localparam int unsigned W = $clog2(TimeoutCycles + 1);
    localparam logic [W-1:0] Last = W'(TimeoutCycles - 1);

    logic [W-1:0] cnt_q;

    assign expire_o = count_i && (cnt_q == Last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (count_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/prim_shadow_writer.sv
// prim_shadow_writer: clear-phase read, two identical writes, verify read of a shadowed register.
// Optional macro PRIM_SHADOW_WRITER_RETRY_EN: retry the full sequence on a verify mismatch.
module prim_shadow_writer import prim_shadow_writer_pkg::*; #(
    parameter int unsigned AW            = 8,
    parameter int unsigned DW            = 32,
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned MaxRetries    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    prim_shadow_writer_if.master sw
);
`ifdef PRIM_SHADOW_WRITER_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif
    localparam int unsigned RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

    shadow_wr_state_e  state_q, state_d;
    shadow_wr_status_e status_q, status_d;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     data_q;
    logic [RW-1:0]     retry_q;
    logic              pend_q, pend_d;
    logic              stor_q;
    logic              in_read, in_write, waiting, expire, accept, retry_take, retry_ok, verify_bad;

    assign in_read    = is_read_state(state_q);
    assign in_write   = is_write_state(state_q);
    // pend_q: read granted, now waiting for rvalid with the request already dropped
    assign waiting    = (in_read || in_write) && (pend_q ? !sw.bus_rvalid_i : !sw.bus_gnt_i);
    assign verify_bad = (sw.bus_rdata_i != data_q) || sw.err_storage_i || stor_q;
    assign retry_ok   = RetryEn && (retry_q < RW'(MaxRetries));

    prim_shadow_wr_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (state_d != state_q),
        .count_i  (waiting),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        pend_d     = pend_q;
        accept     = 1'b0;
        retry_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (sw.upd_valid_i) begin
                    accept   = 1'b1;
                    status_d = OK;
                    state_d  = CLR;
                end
            end
            CLR: begin
                if (!pend_q && sw.bus_gnt_i) begin
                    pend_d = 1'b1;
                end else if (pend_q && sw.bus_rvalid_i) begin
                    pend_d  = 1'b0;
                    state_d = WR0;
                end
            end
            WR0: if (sw.bus_gnt_i) state_d = WR1;
            WR1: begin
                if (sw.bus_gnt_i) begin
                    state_d = sw.err_update_i ? RESP : VFY;
                    if (sw.err_update_i) status_d = UPD_ERR;
                end
            end
            VFY: begin
                if (!pend_q && sw.bus_gnt_i) begin
                    pend_d = 1'b1;
                end else if (pend_q && sw.bus_rvalid_i) begin
                    pend_d = 1'b0;
                    if (!verify_bad) begin
                        state_d = RESP;
                    end else if (retry_ok) begin
                        retry_take = 1'b1;
                        state_d    = CLR;
                    end else begin
                        status_d = MISMATCH;
                        state_d  = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // expire can only fire while an access is still outstanding, so it overrides any advance
        if (expire) begin
            pend_d   = 1'b0;
            status_d = TIMEOUT;
            state_d  = RESP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            status_q <= OK;
            pend_q   <= 1'b0;
            stor_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            pend_q   <= pend_d;
            stor_q   <= (state_q == VFY) && (stor_q || sw.err_storage_i);
            if (accept) begin
                addr_q  <= sw.upd_addr_i;
                data_q  <= sw.upd_data_i;
                retry_q <= '0;
            end else if (retry_take) begin
                retry_q <= retry_q + 1'b1;
            end
        end
    end

    assign sw.upd_ready_o = (state_q == IDLE);
    assign sw.done_o      = (state_q == RESP);
    assign sw.status_o    = status_q;
    assign sw.bus_req_o   = (in_read || in_write) && !pend_q;
    assign sw.bus_we_o    = in_write;
    assign sw.bus_addr_o  = addr_q;
    assign sw.bus_wdata_o = data_q;
endmodule

// File: tb/tb_prim_shadow_writer.sv
// tb_prim_shadow_writer: directed vector table plus reset and held-valid sequences for prim_shadow_writer.
module tb_prim_shadow_writer;
    import prim_shadow_writer_pkg::*;

`ifdef PRIM_SHADOW_WRITER_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    typedef struct {
        logic [7:0]        addr;
        logic [31:0]       data;
        int                gnt_lat;
        logic              err_upd;
        logic              err_stor;
        int                vfy_bad;
        int                withhold;
        shadow_wr_status_e st;
        int                acc;
        logic [7:0]        we;
        int                hold;
        bit                chk_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prim_shadow_writer_if #(.AW(8), .DW(32)) bus_if ();

    prim_shadow_writer #(
        .AW(8), .DW(32), .TimeoutCycles(4), .MaxRetries(1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sw    (bus_if)
    );

    int n_chk = 0;
    int n_fail = 0;

    // responder configuration (written by the stimulus process only)
    logic [7:0]  cur_addr = '0;
    logic [31:0] cur_data = '0;
    int gnt_lat = 0, vfy_bad = 0, withhold = -1, acc_base = 0, rd_base = 0;
    // responder / monitor state (each written by one process only)
    int acc_cnt = 0, rd_cnt = 0, wait_cnt = 0, hold_cnt = 0, bad_acc = 0;
    int done_cnt = 0, hs_cnt = 0;
    logic [63:0] we_hist = '0;
    bit rv_due = 0, rv_vfy = 0, rv_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus target: grants after gnt_lat waiting cycles, returns rdata the cycle after a read grant.
    always @(negedge clk) begin
        bus_if.bus_gnt_i    = 1'b0;
        bus_if.bus_rvalid_i = 1'b0;
        if (rst) begin
            rv_due   = 0;
            wait_cnt = 0;
        end else if (rv_due) begin
            rv_due = 0;
            bus_if.bus_rvalid_i = 1'b1;
            bus_if.bus_rdata_i  = !rv_vfy ? 32'hDEAD_BEEF : (rv_bad ? (cur_data ^ 32'h1) : cur_data);
        end else if (bus_if.bus_req_o) begin
            if (acc_cnt - acc_base == withhold) begin
                hold_cnt++;
            end else if (wait_cnt < gnt_lat) begin
                wait_cnt++;
            end else begin
                bus_if.bus_gnt_i = 1'b1;
                wait_cnt = 0;
                if (bus_if.bus_addr_o !== cur_addr || (bus_if.bus_we_o && bus_if.bus_wdata_o !== cur_data))
                    bad_acc++;
                we_hist = {we_hist[62:0], bus_if.bus_we_o};
                if (!bus_if.bus_we_o) begin
                    rv_due = 1;
                    rv_vfy = ((rd_cnt - rd_base) % 2) == 1;
                    rv_bad = rv_vfy && ((rd_cnt - rd_base) / 2 < vfy_bad);
                    rd_cnt++;
                end
                acc_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus_if.upd_valid_i && bus_if.upd_ready_o) hs_cnt++;
            if (bus_if.done_o) done_cnt++;
        end
    end

    task automatic wait_done(output int n, output bit seen);
        n = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = bus_if.done_o;
        end
    endtask

    task automatic start_update(input logic [7:0] a, input logic [31:0] d);
        cur_addr = a;
        cur_data = d;
        acc_base = acc_cnt;
        rd_base  = rd_cnt;
        bus_if.upd_addr_i  = a;
        bus_if.upd_data_i  = d;
        bus_if.upd_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.upd_valid_i = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n, b_bad, b_hold, b_done;
        bit seen;
        logic [63:0] mask;
        gnt_lat  = v.gnt_lat;
        vfy_bad  = v.vfy_bad;
        withhold = v.withhold;
        bus_if.err_update_i  = v.err_upd;
        bus_if.err_storage_i = v.err_stor;
        b_bad  = bad_acc;
        b_hold = hold_cnt;
        b_done = done_cnt;
        start_update(v.addr, v.data);
        wait_done(n, seen);
        n++;  // first negedge after accept was consumed inside start_update
        check($sformatf("v%0d_done_seen", idx), 64'(seen), 64'd1);
        check($sformatf("v%0d_status", idx), 64'(bus_if.status_o), 64'(v.st));
        check($sformatf("v%0d_accesses", idx), 64'(acc_cnt - acc_base), 64'(v.acc));
        mask = (64'd1 << v.acc) - 64'd1;
        check($sformatf("v%0d_we_pattern", idx), we_hist & mask, 64'(v.we));
        check($sformatf("v%0d_addr_wdata", idx), 64'(bad_acc - b_bad), 64'd0);
        check($sformatf("v%0d_req_hold", idx), 64'(hold_cnt - b_hold), 64'(v.hold));
        // accept cycle through done cycle inclusive = 8 cycles, i.e. done 7 negedges after accept
        if (v.chk_lat) check($sformatf("v%0d_latency", idx), 64'(n), 64'd7);
        @(negedge clk);
        check($sformatf("v%0d_ready_after", idx), 64'(bus_if.upd_ready_o), 64'd1);
        check($sformatf("v%0d_done_pulse", idx), 64'(bus_if.done_o), 64'd0);
        check($sformatf("v%0d_done_count", idx), 64'(done_cnt - b_done), 64'd1);
        withhold = -1;
    endtask

    vec_t vecs[8];

    initial begin
        int n, b_done, b_hs, b_acc, b_bad;
        bit seen;

        vecs[0] = '{8'h10, 32'hA5A5_0F0F, 0, 1'b0, 1'b0, 0, -1, OK, 4, 8'h06, 0, 1'b1};
        vecs[1] = '{8'h22, 32'h1234_5678, 0, 1'b1, 1'b0, 0, -1, UPD_ERR, 3, 8'h03, 0, 1'b0};
        vecs[2] = '{8'h10, 32'hA5A5_0F0F, 0, 1'b0, 1'b0, 2, -1, MISMATCH,
                    RETRY ? 8 : 4, RETRY ? 8'h66 : 8'h06, 0, 1'b0};
        vecs[3] = '{8'h10, 32'hA5A5_0F0F, 0, 1'b0, 1'b0, 1, -1, RETRY ? OK : MISMATCH,
                    RETRY ? 8 : 4, RETRY ? 8'h66 : 8'h06, 0, 1'b0};
        vecs[4] = '{8'h3C, 32'hFFFF_FFFF, 3, 1'b0, 1'b0, 0, -1, OK, 4, 8'h06, 0, 1'b0};
        vecs[5] = '{8'h81, 32'h0000_0000, 0, 1'b0, 1'b1, 0, -1, MISMATCH,
                    RETRY ? 8 : 4, RETRY ? 8'h66 : 8'h06, 0, 1'b0};
        vecs[6] = '{8'h44, 32'h0BAD_F00D, 0, 1'b0, 1'b0, 0, 1, TIMEOUT, 1, 8'h00, 4, 1'b0};
        vecs[7] = '{8'hFF, 32'h8000_0001, 1, 1'b0, 1'b0, 0, -1, OK, 4, 8'h06, 0, 1'b0};

        rst = 1'b1;
        bus_if.upd_valid_i   = 1'b0;
        bus_if.upd_addr_i    = '0;
        bus_if.upd_data_i    = '0;
        bus_if.err_update_i  = 1'b0;
        bus_if.err_storage_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus_if.upd_ready_o), 64'd1);
        check("rst_done", 64'(bus_if.done_o), 64'd0);
        check("rst_status", 64'(bus_if.status_o), 64'(OK));
        check("rst_req", 64'(bus_if.bus_req_o), 64'd0);
        check("rst_we", 64'(bus_if.bus_we_o), 64'd0);
        check("rst_addr", 64'(bus_if.bus_addr_o), 64'd0);
        check("rst_wdata", 64'(bus_if.bus_wdata_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // reset pulsed while WR1 is waiting for its grant
        bus_if.err_update_i  = 1'b0;
        bus_if.err_storage_i = 1'b0;
        gnt_lat  = 0;
        vfy_bad  = 0;
        withhold = 2;
        b_done   = done_cnt;
        start_update(8'h5A, 32'hCAFE_0001);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            seen = (acc_cnt - acc_base == 2) && bus_if.bus_req_o && bus_if.bus_we_o;
            if (!seen) @(negedge clk);
        end
        check("rst_mid_reached_wr1", 64'(seen), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_req_drop", 64'(bus_if.bus_req_o), 64'd0);
        check("rst_mid_ready", 64'(bus_if.upd_ready_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        withhold = -1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", 64'(done_cnt - b_done), 64'd0);
        run_vec(8, vecs[0]);

        // upd_valid_i held high: busy-time requests ignored, next accepted right after done
        b_hs  = hs_cnt;
        b_done = done_cnt;
        b_acc = acc_cnt;
        b_bad = bad_acc;
        cur_addr = 8'h66;
        cur_data = 32'h0F0F_A5A5;
        acc_base = acc_cnt;
        rd_base  = rd_cnt;
        bus_if.upd_addr_i  = 8'h66;
        bus_if.upd_data_i  = 32'h0F0F_A5A5;
        bus_if.upd_valid_i = 1'b1;
        wait_done(n, seen);
        check("hold_first_done", 64'(seen), 64'd1);
        check("hold_one_accept", 64'(hs_cnt - b_hs), 64'd1);
        @(negedge clk);
        cur_addr = 8'h67;
        cur_data = 32'h1111_2222;
        rd_base  = rd_cnt;
        bus_if.upd_addr_i = 8'h67;
        bus_if.upd_data_i = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        bus_if.upd_valid_i = 1'b0;
        check("hold_second_accept", 64'(hs_cnt - b_hs), 64'd2);
        wait_done(n, seen);
        check("hold_second_done", 64'(seen), 64'd1);
        check("hold_second_status", 64'(bus_if.status_o), 64'(OK));
        @(negedge clk);
        check("hold_done_count", 64'(done_cnt - b_done), 64'd2);
        check("hold_accesses", 64'(acc_cnt - b_acc), 64'd8);
        check("hold_addr_wdata", 64'(bad_acc - b_bad), 64'd0);
        check("hold_accept_count", 64'(hs_cnt - b_hs), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
